// File: rtl/tsp_pkg.sv
// Shared TS-path definitions: packet geometry, arbiter state encoding and the
// round-robin winner search used by the output arbiter and pump sequencing.
package tsp_pkg;

    localparam int         PACK_BYTE_SIZE = 188;
    localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;

    // Upper bound on sources handled by rr_pick; the request vector is zero-extended to it.
    localparam int RR_MAX_SRC = 32;
    localparam int RR_SEL_W   = 5;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        PACKET = 1'b1
    } state_t;

    // Scan last+1 .. n-1, then 1 .. last; index 0 is the fallback when nobody asks.
    function automatic int rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                   input int                    last,
                                   input int                    n);
        int                  win;
        int                  cand;
        logic                found;
        logic [RR_SEL_W-1:0] sel;
        win   = 0;
        found = 1'b0;
        for (int k = 1; k < RR_MAX_SRC; k++) begin
            cand = (last + k >= n) ? (last + k - n + 1) : (last + k);
            sel  = RR_SEL_W'(cand);
            if (!found && (k < n) && req[sel]) begin
                win   = cand;
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational winner search over req[NUM_SRC-1:1] with a
// registered last-winner pointer that advances only when a replacer is taken.
module rr_arbiter
    import tsp_pkg::*;
#(
    parameter int NUM_SRC = 10,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               update,
    output logic [IDX_W-1:0]   win_idx
);

    logic [RR_MAX_SRC-1:0] req_ext_s;
    logic [IDX_W-1:0]      last_r;

    // Winner search against the current pointer.
    always_comb begin
        req_ext_s              = {RR_MAX_SRC{1'b0}};
        req_ext_s[NUM_SRC-1:0] = req;
        win_idx                = IDX_W'(rr_pick(req_ext_s, int'(last_r), NUM_SRC));
    end

    // Last-winner pointer; source 0 wins never move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= {IDX_W{1'b0}};
        end else if (update && (win_idx != {IDX_W{1'b0}})) begin
            last_r <= win_idx;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/ts_out_arbiter.sv
// Packet-boundary arbiter sharing one TS output byte lane between NUM_SRC streams;
// ownership changes only on a sync byte and lasts one full packet.
module ts_out_arbiter #(
    parameter int NUM_SRC        = 10,
    parameter int IDX_W          = 4,
    parameter int PACK_BYTE_SIZE = tsp_pkg::PACK_BYTE_SIZE,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_sync,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   grant,
    output logic [IDX_W-1:0]     grant_index,
    output logic                 ts_out_valid,
    output logic                 ts_out_sync,
    output logic [7:0]           ts_out,
    output logic                 hunting,
    output logic [ERR_CNT_W-1:0] sync_err_count
);

    import tsp_pkg::*;

    localparam int               CNT_W    = $clog2(PACK_BYTE_SIZE + 1);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACK_BYTE_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_r, state_n;
    logic [NUM_SRC-1:0]     grant_r, grant_n;
    logic [IDX_W-1:0]       gidx_r, gidx_n;
    logic [CNT_W-1:0]       cnt_r, cnt_n;
    logic                   out_valid_r, out_valid_n;
    logic                   out_sync_r, out_sync_n;
    logic [7:0]             out_data_r, out_data_n;
    logic                   hunting_r;
    logic [ERR_CNT_W-1:0]   err_r;
    logic                   err_inc_s;
    logic                   take_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   own_valid_s, own_sync_s;
    logic [7:0]             own_data_s;
    logic                   win_valid_s, win_sync_s;
    logic [7:0]             win_data_s;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (src_req),
        .update  (take_s),
        .win_idx (win_idx_s)
    );

    // Select the current owner's lane and the prospective winner's lane.
    always_comb begin
        own_valid_s = 1'b0;
        own_sync_s  = 1'b0;
        own_data_s  = 8'h00;
        win_valid_s = 1'b0;
        win_sync_s  = 1'b0;
        win_data_s  = 8'h00;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gidx_r == IDX_W'(k)) begin
                own_valid_s = src_valid[k];
                own_sync_s  = src_sync[k];
                own_data_s  = src_data[8*k +: 8];
            end else begin
                own_valid_s = own_valid_s;
            end
            if (win_idx_s == IDX_W'(k)) begin
                win_valid_s = src_valid[k];
                win_sync_s  = src_sync[k];
                win_data_s  = src_data[8*k +: 8];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Packet framing, boundary detection and next output byte.
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        gidx_n      = gidx_r;
        cnt_n       = cnt_r;
        out_valid_n = 1'b0;
        out_sync_n  = 1'b0;
        out_data_n  = 8'h00;
        err_inc_s   = 1'b0;
        take_s      = 1'b0;
        case (state_r)
            HUNT: begin
                if (src_valid[0] && src_sync[0]) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            PACKET: begin
                if (own_valid_s) begin
                    if (own_sync_s) begin
                        take_s    = 1'b1;
                        err_inc_s = (cnt_r != PKT_LAST);
                    end else if (cnt_r == PKT_LAST) begin
                        // Overlong packet: drop this byte and resynchronise on source 0.
                        err_inc_s = 1'b1;
                        state_n   = HUNT;
                        grant_n   = {NUM_SRC{1'b0}};
                        gidx_n    = {IDX_W{1'b0}};
                        cnt_n     = {CNT_W{1'b0}};
                    end else begin
                        cnt_n       = cnt_r + CNT_ONE;
                        out_valid_n = 1'b1;
                        out_data_n  = own_data_s;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = HUNT;
                grant_n = {NUM_SRC{1'b0}};
                gidx_n  = {IDX_W{1'b0}};
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
        // A boundary hands the lane to the winner starting with its current byte.
        if (take_s) begin
            state_n     = PACKET;
            gidx_n      = win_idx_s;
            grant_n     = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx_s;
            cnt_n       = CNT_ONE;
            out_valid_n = win_valid_s;
            out_sync_n  = win_sync_s & win_valid_s;
            out_data_n  = win_data_s;
        end else begin
            state_n = state_n;
        end
    end

    // State, ownership and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            grant_r     <= {NUM_SRC{1'b0}};
            gidx_r      <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_sync_r  <= 1'b0;
            out_data_r  <= 8'h00;
            hunting_r   <= 1'b1;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            gidx_r      <= gidx_n;
            cnt_r       <= cnt_n;
            out_valid_r <= out_valid_n;
            out_sync_r  <= out_sync_n;
            out_data_r  <= out_data_n;
            hunting_r   <= (state_n == HUNT);
        end
    end

    // Saturating packet-length violation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= {ERR_CNT_W{1'b0}};
        end else if (err_inc_s && (err_r != {ERR_CNT_W{1'b1}})) begin
            err_r <= err_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_r <= err_r;
        end
    end

    assign grant          = grant_r;
    assign grant_index    = gidx_r;
    assign ts_out_valid   = out_valid_r;
    assign ts_out_sync    = out_sync_r;
    assign ts_out         = out_data_r;
    assign hunting        = hunting_r;
    assign sync_err_count = err_r;

endmodule

// File: tb/tb_ts_out_arbiter.sv
// Directed bench for ts_out_arbiter: aligned 188-byte streams on all sources,
// each source's payload byte tagged with its index so the owner is visible on ts_out.
module tb_ts_out_arbiter;

    localparam int NUM_SRC = 10;
    localparam int IDX_W   = 4;
    localparam int ERR_W   = 16;
    localparam int PKT     = 188;

    logic                 clk;
    logic                 rst;
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_sync;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   grant;
    logic [IDX_W-1:0]     grant_index;
    logic                 ts_out_valid;
    logic                 ts_out_sync;
    logic [7:0]           ts_out;
    logic                 hunting;
    logic [ERR_W-1:0]     sync_err_count;

    int n_cmp = 0;
    int n_bad = 0;

    ts_out_arbiter #(
        .NUM_SRC        (NUM_SRC),
        .IDX_W          (IDX_W),
        .PACK_BYTE_SIZE (PKT),
        .ERR_CNT_W      (ERR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_req        (src_req),
        .src_valid      (src_valid),
        .src_sync       (src_sync),
        .src_data       (src_data),
        .grant          (grant),
        .grant_index    (grant_index),
        .ts_out_valid   (ts_out_valid),
        .ts_out_sync    (ts_out_sync),
        .ts_out         (ts_out),
        .hunting        (hunting),
        .sync_err_count (sync_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

    // Byte that source k presents at packet position p (sync bytes are 8'h47).
    function automatic logic [7:0] exp_byte(input int k, input int p, input logic s);
        return s ? 8'h47 : 8'((k * 16) + (p % 16));
    endfunction

    task automatic drive(input logic [NUM_SRC-1:0] req, input int p,
                         input logic sync_all, input logic valid_all);
        src_req = req;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_valid[k]       = valid_all;
            src_sync[k]        = sync_all & valid_all;
            src_data[8*k +: 8] = exp_byte(k, p, sync_all);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(10'b0, 1, 1'b1, 1'b1);
        tick;
        tick;
        n_cmp++;
        if ({grant, grant_index, ts_out_valid, ts_out_sync, ts_out} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got grant=%b idx=%0d v=%b s=%b d=%h, expected all zero",
                     grant, grant_index, ts_out_valid, ts_out_sync, ts_out);
        end
        n_cmp++;
        if (hunting !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hunting: got %b, expected 1", hunting);
        end
        n_cmp++;
        if (sync_err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_err: got %0d, expected 0", sync_err_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_through;
        for (int pk = 0; pk < 2; pk++) begin
            for (int p = 1; p <= PKT; p++) begin
                drive(10'b0, p, p == 1, 1'b1);
                tick;
                n_cmp++;
                if ({ts_out_valid, ts_out_sync, ts_out, grant} !==
                    {1'b1, (p == 1), exp_byte(0, p, p == 1), 10'b00_0000_0001}) begin
                    n_bad++;
                    $display("FAIL pass_through pkt=%0d byte=%0d: got v=%b s=%b d=%h grant=%b, expected v=1 s=%b d=%h grant=0000000001",
                             pk, p, ts_out_valid, ts_out_sync, ts_out, grant, (p == 1), exp_byte(0, p, p == 1));
                end
            end
        end
        n_cmp++;
        if ({sync_err_count, hunting} !== {16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL pass_through_status: got err=%0d hunting=%b, expected err=0 hunting=0",
                     sync_err_count, hunting);
        end
    endtask

    task automatic test_round_robin;
        int owners [4] = '{1, 2, 1, 2};
        for (int pk = 0; pk < 4; pk++) begin
            for (int p = 1; p <= PKT; p++) begin
                drive(10'b00_0000_0110, p, p == 1, 1'b1);
                tick;
                n_cmp++;
                if ({ts_out_valid, ts_out_sync, ts_out, grant_index} !==
                    {1'b1, (p == 1), exp_byte(owners[pk], p, p == 1), 4'(owners[pk])}) begin
                    n_bad++;
                    $display("FAIL round_robin pkt=%0d byte=%0d: got v=%b s=%b d=%h idx=%0d, expected v=1 s=%b d=%h idx=%0d",
                             pk, p, ts_out_valid, ts_out_sync, ts_out, grant_index,
                             (p == 1), exp_byte(owners[pk], p, p == 1), owners[pk]);
                end
            end
        end
    endtask

    task automatic test_req_drop;
        for (int p = 1; p <= PKT; p++) begin
            drive((p < 50) ? 10'b00_0000_0010 : 10'b0, p, p == 1, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, ts_out, grant_index} !== {1'b1, exp_byte(1, p, p == 1), 4'd1}) begin
                n_bad++;
                $display("FAIL req_drop byte=%0d: got v=%b d=%h idx=%0d, expected v=1 d=%h idx=1",
                         p, ts_out_valid, ts_out, grant_index, exp_byte(1, p, p == 1));
            end
        end
        n_cmp++;
        if (sync_err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL req_drop_err: got %0d, expected 0", sync_err_count);
        end
    endtask

    task automatic test_early_sync;
        for (int p = 1; p < 100; p++) begin
            drive(10'b0, p, p == 1, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, ts_out, grant} !== {1'b1, exp_byte(0, p, p == 1), 10'b00_0000_0001}) begin
                n_bad++;
                $display("FAIL early_sync_src0 byte=%0d: got v=%b d=%h grant=%b, expected v=1 d=%h grant=0000000001",
                         p, ts_out_valid, ts_out, grant, exp_byte(0, p, p == 1));
            end
        end
        drive(10'b00_0000_0100, 100, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({ts_out_valid, ts_out_sync, ts_out, grant_index, sync_err_count} !==
            {1'b1, 1'b1, 8'h47, 4'd2, 16'd1}) begin
            n_bad++;
            $display("FAIL early_sync_boundary: got v=%b s=%b d=%h idx=%0d err=%0d, expected v=1 s=1 d=47 idx=2 err=1",
                     ts_out_valid, ts_out_sync, ts_out, grant_index, sync_err_count);
        end
        for (int p = 2; p <= PKT; p++) begin
            drive(10'b0, p, 1'b0, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, ts_out, grant_index} !== {1'b1, exp_byte(2, p, 1'b0), 4'd2}) begin
                n_bad++;
                $display("FAIL early_sync_newpkt byte=%0d: got v=%b d=%h idx=%0d, expected v=1 d=%h idx=2",
                         p, ts_out_valid, ts_out, grant_index, exp_byte(2, p, 1'b0));
            end
        end
    endtask

    task automatic test_missing_sync;
        drive(10'b0, 189, 1'b0, 1'b1);
        tick;
        n_cmp++;
        if ({ts_out_valid, hunting, grant, grant_index, sync_err_count} !==
            {1'b0, 1'b1, 10'b0, 4'd0, 16'd2}) begin
            n_bad++;
            $display("FAIL missing_sync: got v=%b hunting=%b grant=%b idx=%0d err=%0d, expected v=0 hunting=1 grant=0 idx=0 err=2",
                     ts_out_valid, hunting, grant, grant_index, sync_err_count);
        end
        for (int j = 0; j < 4; j++) begin
            drive(10'b0, 190 + j, 1'b0, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, hunting} !== 2'b01) begin
                n_bad++;
                $display("FAIL hunt_hold cycle=%0d: got v=%b hunting=%b, expected v=0 hunting=1",
                         j, ts_out_valid, hunting);
            end
        end
        drive(10'b00_0000_1000, 1, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({ts_out_valid, ts_out_sync, ts_out, grant_index, grant, hunting} !==
            {1'b1, 1'b1, 8'h47, 4'd3, 10'b00_0000_1000, 1'b0}) begin
            n_bad++;
            $display("FAIL hunt_exit: got v=%b s=%b d=%h idx=%0d grant=%b hunting=%b, expected v=1 s=1 d=47 idx=3 grant=0000001000 hunting=0",
                     ts_out_valid, ts_out_sync, ts_out, grant_index, grant, hunting);
        end
        for (int p = 2; p <= PKT; p++) begin
            drive(10'b0, p, 1'b0, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, ts_out, grant_index} !== {1'b1, exp_byte(3, p, 1'b0), 4'd3}) begin
                n_bad++;
                $display("FAIL hunt_exit_pkt byte=%0d: got v=%b d=%h idx=%0d, expected v=1 d=%h idx=3",
                         p, ts_out_valid, ts_out, grant_index, exp_byte(3, p, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int p = 1; p < 90; p++) begin
            drive(10'b0, p, p == 1, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, ts_out, grant_index} !== {1'b1, exp_byte(0, p, p == 1), 4'd0}) begin
                n_bad++;
                $display("FAIL pre_reset byte=%0d: got v=%b d=%h idx=%0d, expected v=1 d=%h idx=0",
                         p, ts_out_valid, ts_out, grant_index, exp_byte(0, p, p == 1));
            end
        end
        rst = 1'b1;
        drive(10'b0, 90, 1'b0, 1'b1);
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({grant, grant_index, ts_out_valid, ts_out_sync, ts_out, hunting, sync_err_count} !==
            {10'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0}) begin
            n_bad++;
            $display("FAIL mid_reset: got grant=%b idx=%0d v=%b s=%b d=%h hunting=%b err=%0d, expected zeros with hunting=1",
                     grant, grant_index, ts_out_valid, ts_out_sync, ts_out, hunting, sync_err_count);
        end
        for (int p = 91; p <= 95; p++) begin
            drive(10'b0, p, 1'b0, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, hunting} !== 2'b01) begin
                n_bad++;
                $display("FAIL post_reset_hunt byte=%0d: got v=%b hunting=%b, expected v=0 hunting=1",
                         p, ts_out_valid, hunting);
            end
        end
        // Pointer was cleared by reset, so source 1 beats source 4.
        drive(10'b00_0001_0010, 1, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({ts_out_valid, ts_out_sync, ts_out, grant_index} !== {1'b1, 1'b1, 8'h47, 4'd1}) begin
            n_bad++;
            $display("FAIL post_reset_sync: got v=%b s=%b d=%h idx=%0d, expected v=1 s=1 d=47 idx=1",
                     ts_out_valid, ts_out_sync, ts_out, grant_index);
        end
        drive(10'b0, 2, 1'b0, 1'b0);
        tick;
        n_cmp++;
        if ({ts_out_valid, grant_index, hunting} !== {1'b0, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL owner_gap: got v=%b idx=%0d hunting=%b, expected v=0 idx=1 hunting=0",
                     ts_out_valid, grant_index, hunting);
        end
        for (int p = 2; p <= PKT; p++) begin
            drive(10'b0, p, 1'b0, 1'b1);
            tick;
            n_cmp++;
            if ({ts_out_valid, ts_out, grant_index} !== {1'b1, exp_byte(1, p, 1'b0), 4'd1}) begin
                n_bad++;
                $display("FAIL gap_pkt byte=%0d: got v=%b d=%h idx=%0d, expected v=1 d=%h idx=1",
                         p, ts_out_valid, ts_out, grant_index, exp_byte(1, p, 1'b0));
            end
        end
        drive(10'b0, 1, 1'b1, 1'b1);
        tick;
        n_cmp++;
        if ({ts_out_valid, ts_out_sync, ts_out, grant_index, sync_err_count} !==
            {1'b1, 1'b1, 8'h47, 4'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL gap_boundary: got v=%b s=%b d=%h idx=%0d err=%0d, expected v=1 s=1 d=47 idx=0 err=0",
                     ts_out_valid, ts_out_sync, ts_out, grant_index, sync_err_count);
        end
    endtask

    initial begin
        rst       = 1'b1;
        src_req   = 10'b0;
        src_valid = 10'b0;
        src_sync  = 10'b0;
        src_data  = 80'h0;
        test_reset;
        test_pass_through;
        test_round_robin;
        test_req_drop;
        test_early_sync;
        test_missing_sync;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
